// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared constants for the hardwired control unit: instruction opcodes,
// ALU_select operation codes, the sequencer state enum and the instruction
// classes produced by control_decode.
// No ports (package).

package cpu_ctrl_pkg;

    // Opcodes, ir[31:27]
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_ST   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_SHR  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_ADDI = 5'd10;
    localparam logic [4:0] OP_ANDI = 5'd11;
    localparam logic [4:0] OP_ORI  = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;
    localparam logic [4:0] OP_NEG  = 5'd15;
    localparam logic [4:0] OP_NOT  = 5'd16;
    localparam logic [4:0] OP_MFHI = 5'd17;
    localparam logic [4:0] OP_MFLO = 5'd18;
    localparam logic [4:0] OP_NOP  = 5'd19;
    localparam logic [4:0] OP_HALT = 5'd20;

    // ALU_select codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_e;

    // Execute-sequence families
    typedef enum logic [3:0] {
        CL_NOP    = 4'd0,
        CL_RTYPE  = 4'd1,
        CL_ITYPE  = 4'd2,
        CL_UNARY  = 4'd3,
        CL_MULDIV = 4'd4,
        CL_MFHI   = 4'd5,
        CL_MFLO   = 4'd6,
        CL_LD     = 4'd7,
        CL_ST     = 4'd8,
        CL_HALT   = 4'd9
    } class_e;

    // True in the states where an instruction is being fetched or executed.
    function automatic logic is_run_state(input state_e s);
        return (s != S_IDLE) && (s != S_HALTED);
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode
// Combinational instruction decoder. Maps the instruction register to an
// execute-sequence class, the ALU operation code and one-hot Ra/Rb/Rc
// register selects.
// Configuration: MUL_DIV_EN -- when undefined, mul/div/mfhi/mflo decode
// as nop.
// Ports:
//   ir          in  32       instruction register (opcode + register fields)
//   instr_class out class_e  execute-sequence family
//   alu_sel     out 4        ALU_select code for the operate step
//   ra_oh       out REG_CNT  one-hot Ra (ir[26:23])
//   rb_oh       out REG_CNT  one-hot Rb (ir[22:19])
//   rc_oh       out REG_CNT  one-hot Rc (ir[18:15])

module control_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_CNT = 16
) (
    input  logic [31:0]        ir,
    output class_e             instr_class,
    output logic [3:0]         alu_sel,
    output logic [REG_CNT-1:0] ra_oh,
    output logic [REG_CNT-1:0] rb_oh,
    output logic [REG_CNT-1:0] rc_oh
);

    localparam logic [REG_CNT-1:0] ONE = REG_CNT'(1);

    logic [4:0] opcode;
    logic       ir_unused;

    assign opcode    = ir[31:27];
    // Immediate field is consumed by the datapath, not by control.
    assign ir_unused = ^ir[14:0];

    // A register index at or above REG_CNT shifts out, giving no strobe.
    assign ra_oh = ONE << ir[26:23];
    assign rb_oh = ONE << ir[22:19];
    assign rc_oh = ONE << ir[18:15];

    always_comb begin
        instr_class = CL_NOP;
        alu_sel     = ALU_ADD;
        case (opcode)
            OP_LD:   begin instr_class = CL_LD;    alu_sel = ALU_ADD; end
            OP_ST:   begin instr_class = CL_ST;    alu_sel = ALU_ADD; end
            OP_ADD:  begin instr_class = CL_RTYPE; alu_sel = ALU_ADD; end
            OP_SUB:  begin instr_class = CL_RTYPE; alu_sel = ALU_SUB; end
            OP_AND:  begin instr_class = CL_RTYPE; alu_sel = ALU_AND; end
            OP_OR:   begin instr_class = CL_RTYPE; alu_sel = ALU_OR;  end
            OP_SHR:  begin instr_class = CL_RTYPE; alu_sel = ALU_SHR; end
            OP_SHL:  begin instr_class = CL_RTYPE; alu_sel = ALU_SHL; end
            OP_ROR:  begin instr_class = CL_RTYPE; alu_sel = ALU_ROR; end
            OP_ROL:  begin instr_class = CL_RTYPE; alu_sel = ALU_ROL; end
            OP_ADDI: begin instr_class = CL_ITYPE; alu_sel = ALU_ADD; end
            OP_ANDI: begin instr_class = CL_ITYPE; alu_sel = ALU_AND; end
            OP_ORI:  begin instr_class = CL_ITYPE; alu_sel = ALU_OR;  end
`ifdef MUL_DIV_EN
            OP_MUL:  begin instr_class = CL_MULDIV; alu_sel = ALU_MUL; end
            OP_DIV:  begin instr_class = CL_MULDIV; alu_sel = ALU_DIV; end
            OP_MFHI: instr_class = CL_MFHI;
            OP_MFLO: instr_class = CL_MFLO;
`endif
            OP_NEG:  begin instr_class = CL_UNARY; alu_sel = ALU_NEG; end
            OP_NOT:  begin instr_class = CL_UNARY; alu_sel = ALU_NOT; end
            OP_NOP:  instr_class = CL_NOP;
            OP_HALT: instr_class = CL_HALT;
            default: instr_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the 32-bit bus datapath. Runs the
// fetch/decode/execute cycle and drives every datapath strobe as a
// combinational decode of the state register and ir.
// Configuration: MUL_DIV_EN -- enables mul/div/mfhi/mflo; when undefined
// those opcodes act as nop and HI_in/LO_in/HIout/LOout/ZHIout stay 0.
// Ports:
//   clk        in  1        rising-edge clock
//   clr        in  1        asynchronous active-low reset
//   start      in  1        leave IDLE and begin fetching
//   ir         in  32       instruction register contents
//   mem_ready  in  1        memory read/write complete
//   r_in       out REG_CNT  one-hot register load strobe
//   r_out      out REG_CNT  one-hot register bus-drive strobe
//   PC_in .. MDR_in  out 1  load strobes
//   PCout .. Cout    out 1  bus-drive strobes
//   read, write      out 1  memory strobes
//   ALU_select out 4        ALU operation code
//   run        out 1        high from F0 through T7

module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_CNT = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [31:0]        ir,
    input  logic               mem_ready,
    output logic [REG_CNT-1:0] r_in,
    output logic [REG_CNT-1:0] r_out,
    output logic               PC_in,
    output logic               Inc_PC,
    output logic               IR_in,
    output logic               Y_in,
    output logic               Z_in,
    output logic               HI_in,
    output logic               LO_in,
    output logic               MAR_in,
    output logic               MDR_in,
    output logic               PCout,
    output logic               ZLOWout,
    output logic               ZHIout,
    output logic               LOout,
    output logic               HIout,
    output logic               MDRout,
    output logic               Cout,
    output logic               read,
    output logic               write,
    output logic [3:0]         ALU_select,
    output logic               run
);

    state_e               state_q;
    state_e               state_d;
    class_e               instr_class;
    logic [3:0]           alu_sel;
    logic [REG_CNT-1:0]   ra_oh;
    logic [REG_CNT-1:0]   rb_oh;
    logic [REG_CNT-1:0]   rc_oh;

    control_decode #(
        .REG_CNT (REG_CNT)
    ) u_decode (
        .ir          (ir),
        .instr_class (instr_class),
        .alu_sel     (alu_sel),
        .ra_oh       (ra_oh),
        .rb_oh       (rb_oh),
        .rc_oh       (rc_oh)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes. IDLE and HALTED assert nothing, so reset
    // clears every output in the same cycle it forces IDLE.
    always_comb begin
        state_d    = state_q;
        r_in       = '0;
        r_out      = '0;
        PC_in      = 1'b0;
        Inc_PC     = 1'b0;
        IR_in      = 1'b0;
        Y_in       = 1'b0;
        Z_in       = 1'b0;
        HI_in      = 1'b0;
        LO_in      = 1'b0;
        MAR_in     = 1'b0;
        MDR_in     = 1'b0;
        PCout      = 1'b0;
        ZLOWout    = 1'b0;
        ZHIout     = 1'b0;
        LOout      = 1'b0;
        HIout      = 1'b0;
        MDRout     = 1'b0;
        Cout       = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        ALU_select = '0;
        run        = is_run_state(state_q);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_F0;
            end

            S_F0: begin
                PCout   = 1'b1;
                MAR_in  = 1'b1;
                Inc_PC  = 1'b1;
                state_d = S_F1;
            end

            S_F1: begin
                read = 1'b1;
                if (mem_ready) begin
                    MDR_in  = 1'b1;
                    state_d = S_F2;
                end
            end

            S_F2: begin
                MDRout  = 1'b1;
                IR_in   = 1'b1;
                state_d = S_T3;
            end

            S_T3: begin
                state_d = S_T4;
                case (instr_class)
                    CL_RTYPE, CL_ITYPE, CL_LD, CL_ST: begin
                        r_out = rb_oh;
                        Y_in  = 1'b1;
                    end
                    CL_UNARY: begin
                        r_out      = rb_oh;
                        ALU_select = alu_sel;
                        Z_in       = 1'b1;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        r_out = ra_oh;
                        Y_in  = 1'b1;
                    end
                    CL_MFHI: begin
                        HIout   = 1'b1;
                        r_in    = ra_oh;
                        state_d = S_F0;
                    end
                    CL_MFLO: begin
                        LOout   = 1'b1;
                        r_in    = ra_oh;
                        state_d = S_F0;
                    end
`endif
                    CL_HALT: state_d = S_HALTED;
                    default: state_d = S_F0;
                endcase
            end

            S_T4: begin
                state_d = S_T5;
                case (instr_class)
                    CL_RTYPE: begin
                        r_out      = rc_oh;
                        ALU_select = alu_sel;
                        Z_in       = 1'b1;
                    end
                    CL_ITYPE, CL_LD, CL_ST: begin
                        Cout       = 1'b1;
                        ALU_select = alu_sel;
                        Z_in       = 1'b1;
                    end
                    CL_UNARY: begin
                        ZLOWout = 1'b1;
                        r_in    = ra_oh;
                        state_d = S_F0;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        r_out      = rb_oh;
                        ALU_select = alu_sel;
                        Z_in       = 1'b1;
                    end
`endif
                    default: state_d = S_F0;
                endcase
            end

            S_T5: begin
                state_d = S_F0;
                case (instr_class)
                    CL_RTYPE, CL_ITYPE: begin
                        ZLOWout = 1'b1;
                        r_in    = ra_oh;
                    end
                    CL_LD, CL_ST: begin
                        ZLOWout = 1'b1;
                        MAR_in  = 1'b1;
                        state_d = S_T6;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ZLOWout = 1'b1;
                        LO_in   = 1'b1;
                        state_d = S_T6;
                    end
`endif
                    default: state_d = S_F0;
                endcase
            end

            S_T6: begin
                state_d = S_F0;
                case (instr_class)
                    CL_LD: begin
                        // Same wait rule as the instruction fetch in F1.
                        read    = 1'b1;
                        state_d = S_T6;
                        if (mem_ready) begin
                            MDR_in  = 1'b1;
                            state_d = S_T7;
                        end
                    end
                    CL_ST: begin
                        r_out   = ra_oh;
                        MDR_in  = 1'b1;
                        state_d = S_T7;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ZHIout = 1'b1;
                        HI_in  = 1'b1;
                    end
`endif
                    default: state_d = S_F0;
                endcase
            end

            S_T7: begin
                state_d = S_F0;
                case (instr_class)
                    CL_LD: begin
                        MDRout = 1'b1;
                        r_in   = ra_oh;
                    end
                    CL_ST: begin
                        write = 1'b1;
                        if (!mem_ready) state_d = S_T7;
                    end
                    default: state_d = S_F0;
                endcase
            end

            S_HALTED: state_d = S_HALTED;

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed and randomized instruction streams against a cycle-by-cycle
// reference plan built from the instruction-class rules of the control unit.
// Configuration: MUL_DIV_EN -- the reference plan follows the same macro.

module tb_control_sequencer;

    localparam int unsigned REG_CNT = 16;
`ifdef MUL_DIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in;
        logic pcout, zlowout, zhiout, loout, hiout, mdrout, cout;
        logic rd, wr;
        logic [3:0] alu;
        logic run;
    } vec_t;

    typedef struct {
        vec_t  v;
        bit    waits;
        bit    mdr_on_ready;
        string name;
    } step_t;

    logic clk = 1'b0;
    logic clr, start, mem_ready;
    logic [31:0] ir;
    logic [REG_CNT-1:0] r_in, r_out;
    logic PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
    logic PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, Cout, read, write;
    logic [3:0] ALU_select;
    logic run;

    int vectors = 0;
    int miscompares = 0;
    step_t plan[$];
    vec_t zero_v = '0;

    always #5 clk = ~clk;

    control_sequencer #(.REG_CNT(REG_CNT)) dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
        .r_in(r_in), .r_out(r_out),
        .PC_in(PC_in), .Inc_PC(Inc_PC), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
        .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
        .PCout(PCout), .ZLOWout(ZLOWout), .ZHIout(ZHIout), .LOout(LOout),
        .HIout(HIout), .MDRout(MDRout), .Cout(Cout),
        .read(read), .write(write), .ALU_select(ALU_select), .run(run)
    );

    function automatic vec_t observed();
        vec_t o;
        o.r_in = r_in;       o.r_out = r_out;
        o.pc_in = PC_in;     o.inc_pc = Inc_PC;   o.ir_in = IR_in;
        o.y_in = Y_in;       o.z_in = Z_in;       o.hi_in = HI_in;
        o.lo_in = LO_in;     o.mar_in = MAR_in;   o.mdr_in = MDR_in;
        o.pcout = PCout;     o.zlowout = ZLOWout; o.zhiout = ZHIout;
        o.loout = LOout;     o.hiout = HIout;     o.mdrout = MDRout;
        o.cout = Cout;       o.rd = read;         o.wr = write;
        o.alu = ALU_select;  o.run = run;
        return o;
    endfunction

    function automatic logic [3:0] alu_of(input int op);
        case (op)
            3: return 4'd1;   4: return 4'd2;   5: return 4'd3;
            6: return 4'd4;   7: return 4'd5;   8: return 4'd6;
            9: return 4'd7;   11: return 4'd2;  12: return 4'd3;
            13: return 4'd8;  14: return 4'd9;  15: return 4'd10;
            16: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input vec_t exp, input string tag);
        vec_t obs;
        obs = observed();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are
    // checked on the falling edge of the same cycle.
    task automatic cycle(input vec_t exp, input string tag);
        @(negedge clk);
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v, input string n, input bit w, input bit m);
        step_t s;
        s.v = v; s.name = n; s.waits = w; s.mdr_on_ready = m;
        plan.push_back(s);
    endtask

    // Reference plan: one entry per state visited, from the instruction rules.
    task automatic build_plan(input int op, input int ra, input int rb, input int rc);
        vec_t v;
        logic [15:0] a, b, c;
        a = 16'h1 << ra;
        b = 16'h1 << rb;
        c = 16'h1 << rc;
        plan.delete();
        v = zero_v; v.run = 1; v.pcout = 1; v.mar_in = 1; v.inc_pc = 1; push(v, "F0", 0, 0);
        v = zero_v; v.run = 1; v.rd = 1;                                 push(v, "F1", 1, 1);
        v = zero_v; v.run = 1; v.mdrout = 1; v.ir_in = 1;                push(v, "F2", 0, 0);
        if (op >= 2 && op <= 12) begin
            v = zero_v; v.run = 1; v.r_out = b; v.y_in = 1; push(v, "T3", 0, 0);
            v = zero_v; v.run = 1; v.alu = alu_of(op); v.z_in = 1;
            if (op <= 9) v.r_out = c; else v.cout = 1;
            push(v, "T4", 0, 0);
            v = zero_v; v.run = 1; v.zlowout = 1; v.r_in = a; push(v, "T5", 0, 0);
        end else if ((op == 13 || op == 14) && MD_EN) begin
            v = zero_v; v.run = 1; v.r_out = a; v.y_in = 1; push(v, "T3", 0, 0);
            v = zero_v; v.run = 1; v.r_out = b; v.alu = alu_of(op); v.z_in = 1; push(v, "T4", 0, 0);
            v = zero_v; v.run = 1; v.zlowout = 1; v.lo_in = 1; push(v, "T5", 0, 0);
            v = zero_v; v.run = 1; v.zhiout = 1; v.hi_in = 1; push(v, "T6", 0, 0);
        end else if (op == 15 || op == 16) begin
            v = zero_v; v.run = 1; v.r_out = b; v.alu = alu_of(op); v.z_in = 1; push(v, "T3", 0, 0);
            v = zero_v; v.run = 1; v.zlowout = 1; v.r_in = a; push(v, "T4", 0, 0);
        end else if ((op == 17 || op == 18) && MD_EN) begin
            v = zero_v; v.run = 1; v.r_in = a;
            if (op == 17) v.hiout = 1; else v.loout = 1;
            push(v, "T3", 0, 0);
        end else if (op <= 1) begin
            v = zero_v; v.run = 1; v.r_out = b; v.y_in = 1; push(v, "T3", 0, 0);
            v = zero_v; v.run = 1; v.cout = 1; v.z_in = 1; push(v, "T4", 0, 0);
            v = zero_v; v.run = 1; v.zlowout = 1; v.mar_in = 1; push(v, "T5", 0, 0);
            if (op == 0) begin
                v = zero_v; v.run = 1; v.rd = 1; push(v, "T6", 1, 1);
                v = zero_v; v.run = 1; v.mdrout = 1; v.r_in = a; push(v, "T7", 0, 0);
            end else begin
                v = zero_v; v.run = 1; v.r_out = a; v.mdr_in = 1; push(v, "T6", 0, 0);
                v = zero_v; v.run = 1; v.wr = 1; push(v, "T7", 1, 0);
            end
        end else begin
            v = zero_v; v.run = 1; push(v, "T3", 0, 0);
        end
    endtask

    // stall < 0 picks a random stall per wait state; abort_at >= 0 pulses
    // clr during that step and returns with the sequencer reset.
    task automatic exec(input int op, input int ra, input int rb, input int rc,
                        input int stall, input int abort_at);
        logic [31:0] instr;
        instr = {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'($urandom)};
        build_plan(op, ra, rb, rc);
        for (int s = 0; s < plan.size(); s++) begin
            string nm;
            nm = $sformatf("op%0d/%s", op, plan[s].name);
            start = 1'($urandom_range(0, 1));
            ir = (s < 3) ? $urandom : instr;
            if (plan[s].waits) begin
                int k;
                vec_t e;
                k = (stall >= 0) ? stall : int'($urandom_range(0, 3));
                for (int j = 0; j < k; j++) begin
                    mem_ready = 1'b0;
                    cycle(plan[s].v, {nm, "/wait"});
                end
                mem_ready = 1'b1;
                e = plan[s].v;
                if (plan[s].mdr_on_ready) e.mdr_in = 1'b1;
                cycle(e, {nm, "/ready"});
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                if (s == abort_at) begin
                    @(negedge clk);
                    check(plan[s].v, nm);
                    #1 clr = 1'b0;
                    #1 check(zero_v, "clr_mid_instr");
                    #1 clr = 1'b1;
                    return;
                end
                cycle(plan[s].v, nm);
            end
        end
    endtask

    initial begin
        int op;
        clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
        #2 check(zero_v, "reset");
        @(posedge clk); #1;
        start = 1'b1;
        cycle(zero_v, "reset_held_start");
        clr = 1'b1; start = 1'b0;
        cycle(zero_v, "idle0");
        cycle(zero_v, "idle1");
        start = 1'b1;
        cycle(zero_v, "idle_start");

        exec(2, 1, 2, 3, 0, -1);    // add R1,R2,R3
        exec(3, 7, 8, 9, 3, -1);    // sub with 3-cycle fetch stall
        exec(0, 4, 2, 0, 0, -1);    // ld R4,0x10(R2)
        exec(0, 6, 1, 0, 2, -1);    // ld with stalls
        exec(1, 3, 5, 0, 2, -1);    // st with stalls
        exec(13, 5, 6, 0, 0, -1);   // mul R5,R6
        exec(14, 2, 9, 0, -1, -1);  // div
        exec(17, 11, 0, 0, 0, -1);  // mfhi
        exec(18, 12, 0, 0, 0, -1);  // mflo
        exec(15, 1, 14, 0, -1, -1); // neg
        exec(16, 15, 0, 0, -1, -1); // not
        exec(10, 3, 4, 0, -1, -1);  // addi
        exec(12, 0, 15, 0, -1, -1); // ori
        exec(25, 2, 3, 4, -1, -1);  // undefined opcode
        exec(19, 1, 1, 1, -1, -1);  // nop

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 31));
            if (op == 20) op = 19;
            exec(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), -1, -1);
        end

        exec(3, 1, 2, 3, 0, 4);     // sub, clr pulsed in T4
        start = 1'b0;
        cycle(zero_v, "idle_after_clr0");
        cycle(zero_v, "idle_after_clr1");
        start = 1'b1;
        cycle(zero_v, "idle_after_clr_start");
        exec(2, 9, 10, 11, -1, -1);

        exec(20, 0, 0, 0, -1, -1);  // halt
        for (int n = 0; n < 6; n++) begin
            start = n[0];
            mem_ready = 1'($urandom_range(0, 1));
            cycle(zero_v, "halted");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus datapath. It runs the fetch/decode/execute cycle with a state machine, decodes the opcode and register fields of the instruction register, and drives every datapath load/drive strobe and `ALU_select`. It handshakes with memory through `mem_ready`. It sits beside the datapath; the datapath's IR output feeds back into it.

## Interface
- `REG_CNT`, default 16: number of general registers, one-hot strobe width.
- `clk  in  1`: rising-edge clock.
- `clr  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin execution from IDLE.
- `ir  in  32`: instruction register contents.
  - `ir[31:27]` is the opcode.
  - `ir[26:23]` is Ra, `ir[22:19]` is Rb, `ir[18:15]` is Rc.
- `mem_ready  in  1`: memory has completed the current read or write.
- `r_in  out  REG_CNT`: one-hot register load strobe.
- `r_out  out  REG_CNT`: one-hot register bus-drive strobe.
- `PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in  out  1`: load strobes.
- `PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, Cout  out  1`: bus-drive strobes.
- `read, write  out  1`: memory strobes.
- `ALU_select  out  4`: ALU operation code.
- `run  out  1`: high while executing, low in IDLE/HALTED.

## Operation
- States: IDLE, F0, F1, F2, T3, T4, T5, T6, T7, HALTED.
- Strobes not listed for a state are 0. At most one bus-drive strobe is high in any cycle.
- Fetch:
  - F0: `PCout`, `MAR_in`, `Inc_PC`.
  - F1: `read`. Stay in F1 while `mem_ready`=0. In the cycle `mem_ready`=1, also assert `MDR_in`, then go to F2.
  - F2: `MDRout`, `IR_in`, then go to T3.
- Opcodes 0–20, in order: ld, st, add, sub, and, or, shr, shl, ror, rol, addi, andi, ori, mul, div, neg, not, mfhi, mflo, nop, halt.
- ALU codes: add 0, sub 1, and 2, or 3, shr 4, shl 5, ror 6, rol 7, mul 8, div 9, neg 10, not 11. addi/andi/ori use the add/and/or codes.
- Execute sequences (last listed state returns to F0):
  - R-type: T3 Rb out, `Y_in`; T4 Rc out, ALU code, `Z_in`; T5 `ZLOWout`, Ra in.
  - I-type: T3 Rb out, `Y_in`; T4 `Cout`, ALU code, `Z_in`; T5 `ZLOWout`, Ra in.
  - neg/not: T3 Rb out, ALU code, `Z_in`; T4 `ZLOWout`, Ra in.
  - mul/div: T3 Ra out, `Y_in`; T4 Rb out, ALU code, `Z_in`; T5 `ZLOWout`, `LO_in`; T6 `ZHIout`, `HI_in`.
  - mfhi/mflo: T3 `HIout`/`LOout`, Ra in.
  - ld: T3 Rb out, `Y_in`; T4 `Cout`, add, `Z_in`; T5 `ZLOWout`, `MAR_in`; T6 `read` with the F1 wait rule and `MDR_in` on ready; T7 `MDRout`, Ra in.
  - st: T3–T5 as ld; T6 Ra out, `MDR_in`; T7 `write`, wait for `mem_ready`.
  - nop and undefined opcodes 21–31: T3 does nothing, then F0.
  - halt: go to HALTED. HALTED is left only by reset.
- IDLE goes to F0 on `start`=1. `start` is ignored in every other state.
- `mem_ready` is ignored outside F1, T6 (ld) and T7 (st).

## Timing
- `clr`=0 immediately forces IDLE and drives all outputs to 0, including `run`, at any point mid-instruction.
- Leaving reset: the first rising edge with `clr`=1 and `start`=1 enters F0.
- Outputs are combinational decode of the state register and `ir`, valid throughout each state.
- `run`=1 in F0 through T7.
- Latency with `mem_ready` tied high:
  - add: 6 cycles (F0–T5).
  - mul: 7 cycles.
  - ld/st: 8 cycles.
  - mfhi: 4 cycles.
- Each cycle `mem_ready`=0 during a wait state adds one cycle.
- `ir` is sampled only in T3 and later, after `IR_in` has loaded it in F2.

## Configuration
- `MUL_DIV_EN` defined: mul, div, mfhi and mflo execute as above.
- `MUL_DIV_EN` undefined: those four opcodes decode as nop; `HI_in`, `LO_in`, `HIout`, `LOout` and `ZHIout` are tied to 0.

## Structure
- Package `cpu_ctrl_pkg` holds the opcode constants, ALU_select constants and the state enum.
- Sub-module `control_decode`: combinational. It maps `ir` to an instruction class, the ALU code, and one-hot Ra/Rb/Rc.

## Test plan
- Reset, then `start` with `ir`=add R1,R2,R3 and `mem_ready` high:
  - F0 `PCout`/`MAR_in`/`Inc_PC`; F2 `IR_in`; T4 `r_out`=0x0008 with `ALU_select`=0; T5 `r_in`=0x0002; F0 again at cycle 6.
- `mem_ready` low for 3 cycles in F1 → `read` high for 4 cycles; `MDR_in` only in the 4th.
- ld R4,0x10(R2) → T4 `Cout`; T5 `MAR_in`; T7 `MDRout` with `r_in`=0x0010.
- mul R5,R6 → T5 `LO_in`; T6 `ZHIout`/`HI_in`. Without `MUL_DIV_EN`: F0 at cycle 4, no `LO_in` ever.
- Opcode 25 runs as nop. halt → `run`=0 and stays 0 with `start` toggling.
- `clr` pulsed low during T4 of sub → all outputs 0 that same cycle; IDLE until `start`.
